pipeline_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. Generates per-register write enables and bubble/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Covers three cases: load-use hazards, taken-branch flushes, and multi-cycle data-memory accesses. A timeout guards the memory wait. The block holds state only for memory-wait sequencing and the counters; all pipeline controls are combinational from that state and the inputs, so they act in the same cycle.

---
 rtl/pipeline_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch and memory-wait handling.
// Define PIPELINE_CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_write,
  output logic              mem_wb_bubble,
`ifdef PIPELINE_CTRL_PERF_EN
  output logic [PERF_W-1:0] perf_mem_stall,
  output logic [PERF_W-1:0] perf_lu_stall,
  output logic [PERF_W-1:0] perf_flush,
`endif
  output logic              mem_error
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

  if (MEM_TIMEOUT < 2 || (2 ** CNT_W) <= MEM_TIMEOUT || PERF_W < 1) begin : g_bad_params
    $error("pipeline_ctrl: illegal parameter combination");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_error_q, mem_error_d;
  logic             mem_freeze;
  logic             load_use;
  logic             lu_stall;
  logic             br_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Freeze lasts until ready, mem_req drops, or the timeout forces one advancing cycle.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    mem_freeze  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          mem_freeze = 1'b1;
          state_d    = WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!mem_req || mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == LAST_CNT) begin
          state_d     = RUN;
          wait_cnt_d  = '0;
          mem_error_d = 1'b1;
        end else begin
          mem_freeze = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  assign load_use = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    lu_stall      = 1'b0;
    br_flush      = 1'b0;
    if (rst) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_write  = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (mem_freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      lu_stall    = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
      br_flush    = 1'b1;
    end
  end

  assign mem_error = mem_error_q;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_mem_q, perf_mem_d;
  logic [PERF_W-1:0] perf_lu_q, perf_lu_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mem_q   <= '0;
      perf_lu_q    <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_mem_q   <= perf_mem_d;
      perf_lu_q    <= perf_lu_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    perf_mem_d   = perf_mem_q;
    perf_lu_d    = perf_lu_q;
    perf_flush_d = perf_flush_q;
    if (mem_freeze && !rst && (perf_mem_q != '1)) perf_mem_d = perf_mem_q + PERF_W'(1);
    if (lu_stall && (perf_lu_q != '1)) perf_lu_d = perf_lu_q + PERF_W'(1);
    if (br_flush && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + PERF_W'(1);
  end

  assign perf_mem_stall = perf_mem_q;
  assign perf_lu_stall  = perf_lu_q;
  assign perf_flush     = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; control outputs are checked as a 6-bit vector
// {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble}.
module tb_pipeline_ctrl;

  localparam int unsigned PERF_W = 32;

  localparam logic [5:0] CTRL_RESET  = 6'b001101;
  localparam logic [5:0] CTRL_NORMAL = 6'b110010;
  localparam logic [5:0] CTRL_LU     = 6'b000110;
  localparam logic [5:0] CTRL_BR     = 6'b111010;
  localparam logic [5:0] CTRL_FREEZE = 6'b000001;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_mem_read, branch_taken, mem_req, mem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble;
  logic       mem_error;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [PERF_W-1:0] perf_mem_stall, perf_lu_stall, perf_flush;
`endif

  int checkCount = 0;
  int errorCount = 0;

  pipeline_ctrl #(.MEM_TIMEOUT(16), .CNT_W(8), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble),
`ifdef PIPELINE_CTRL_PERF_EN
    .perf_mem_stall(perf_mem_stall), .perf_lu_stall(perf_lu_stall), .perf_flush(perf_flush),
`endif
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                               input logic mread, input logic [4:0] ert, input logic br,
                               input logic mreq, input logic mrdy);
    rst = r; id_rs = rs; id_rt = rt; ex_mem_read = mread; ex_rt = ert;
    branch_taken = br; mem_req = mreq; mem_ready = mrdy;
  endtask

  // Check combinational controls mid-cycle, then move to just after the next rising edge.
  task automatic cycleCheck(input string tag, input logic [5:0] expCtrl, input logic expErr);
    @(negedge clk);
    checkOutput({tag, "_ctrl"},
                {26'd0, pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_bubble},
                {26'd0, expCtrl});
    checkOutput({tag, "_err"}, {31'd0, mem_error}, {31'd0, expErr});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic expErr);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycleCheck(tag, CTRL_NORMAL, expErr);
  endtask

  initial begin
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cycleCheck("reset1", CTRL_RESET, 1'b0);
    applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    cycleCheck("reset2_forced", CTRL_RESET, 1'b0);
    idle("after_reset", 1'b0);

    applyStimulus(1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycleCheck("lu_rs", CTRL_LU, 1'b0);
    idle("lu_one_bubble", 1'b0);
    applyStimulus(1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    cycleCheck("lu_rt", CTRL_LU, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cycleCheck("lu_r0", CTRL_NORMAL, 1'b0);
    applyStimulus(1'b0, 5'd6, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    cycleCheck("lu_nomatch", CTRL_NORMAL, 1'b0);
    applyStimulus(1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    cycleCheck("lu_noload", CTRL_NORMAL, 1'b0);

    applyStimulus(1'b0, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cycleCheck("branch", CTRL_BR, 1'b0);
    applyStimulus(1'b0, 5'd5, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    cycleCheck("branch_lu", CTRL_LU, 1'b0);

    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cycleCheck("mem_ready_now", CTRL_NORMAL, 1'b0);
    applyStimulus(1'b0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    cycleCheck("freeze_over_lu_br", CTRL_FREEZE, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycleCheck("freeze_wait", CTRL_FREEZE, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycleCheck("mem_req_drop", CTRL_NORMAL, 1'b0);
    idle("after_drop", 1'b0);

    // Fresh reset so the perf counters describe only the memory wait plus one load-use.
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycleCheck("reset_perf", CTRL_RESET, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      cycleCheck($sformatf("memwait_c%0d", i), CTRL_FREEZE, 1'b0);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    cycleCheck("memwait_ready", CTRL_NORMAL, 1'b0);
    idle("memwait_run", 1'b0);
    applyStimulus(1'b0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    cycleCheck("perf_lu", CTRL_LU, 1'b0);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
`ifdef PIPELINE_CTRL_PERF_EN
    checkOutput("perf_mem_stall", perf_mem_stall, 32'd3);
    checkOutput("perf_lu_stall", perf_lu_stall, 32'd1);
    checkOutput("perf_flush", perf_flush, 32'd0);
`endif
    @(posedge clk);
    #1;

    for (int i = 1; i <= 15; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      cycleCheck($sformatf("timeout_c%0d", i), CTRL_FREEZE, 1'b0);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycleCheck("timeout_release", CTRL_NORMAL, 1'b0);
    idle("timeout_err_set", 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    cycleCheck("err_sticky_br", CTRL_BR, 1'b1);
    idle("err_sticky", 1'b1);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycleCheck("err_reset1", CTRL_RESET, 1'b1);
    cycleCheck("err_reset2", CTRL_RESET, 1'b0);
    idle("err_cleared", 1'b0);

    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycleCheck("midwait_c1", CTRL_FREEZE, 1'b0);
    cycleCheck("midwait_c2", CTRL_FREEZE, 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycleCheck("midwait_reset", CTRL_RESET, 1'b0);
    idle("midwait_run", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
